alu_div: RTL and testbench

Multi-cycle unsigned integer divider that sits beside `alu` in the execute stage. It performs the inverse of the ALU's add path by doing restoring division: one trial subtraction per cycle, using the same `a + ~b + 1` borrow convention. Start/busy/done handshaking lets the control unit stall while a quotient and remainder are produced.

---
 rtl/alu_div.sv | 125 ++++++++++++
 tb/tb_alu_div.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_div
// Description : Multi-cycle unsigned restoring divider. One trial subtraction
//               per clock using the a + ~b + 1 borrow convention, with
//               start/busy/done handshaking and a divide-by-zero shortcut.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] dividend,
    input  logic [DATA_BITS-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] quotient,
    output logic [DATA_BITS-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int             CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_BITS:0]     prem_q;     // partial remainder
    logic [DATA_BITS-1:0]   qreg_q;     // dividend bits shifting out, quotient bits shifting in
    logic [DATA_BITS-1:0]   dvs_q;      // latched divisor
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_BITS-1:0]   quot_q;
    logic [DATA_BITS-1:0]   rem_q;
    logic                   dbz_q;

    logic [DATA_BITS:0]     shift_rem;
    logic [DATA_BITS+1:0]   trial_sum;
    logic                   no_borrow;
    logic [DATA_BITS:0]     prem_d;
    logic [DATA_BITS-1:0]   qreg_d;

    // One restoring-division step: shift, trial subtract, keep or restore.
    always_comb begin
        shift_rem = {prem_q[DATA_BITS-1:0], qreg_q[DATA_BITS-1]};
        trial_sum = {1'b0, shift_rem}
                  + {1'b0, ~{1'b0, dvs_q}}
                  + {{(DATA_BITS+1){1'b0}}, 1'b1};
        // A set bit shifted out of the partial remainder means the shifted
        // value exceeds any divisor, so it also counts as "no borrow".
        no_borrow = trial_sum[DATA_BITS+1] | prem_q[DATA_BITS];
        prem_d    = no_borrow ? trial_sum[DATA_BITS:0] : shift_rem;
        qreg_d    = {qreg_q[DATA_BITS-2:0], no_borrow};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            qreg_q  <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Divide by zero completes immediately without iterating.
                            quot_q <= '1;
                            rem_q  <= dividend;
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            dvs_q   <= divisor;
                            prem_q  <= '0;
                            qreg_q  <= dividend;
                            cnt_q   <= CNT_LOAD;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    prem_q <= prem_d;
                    qreg_q <= qreg_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= qreg_d;
                        rem_q   <= prem_d[DATA_BITS-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_div
// Description : Self-checking bench for alu_div with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_div;

    localparam int W     = 8;
    localparam int LIMIT = 20;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   passed   = 0;
    int   total    = 0;
    int   done_cnt = 0;
    int   accepted = 0;

    alu_div #(.DATA_BITS(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Count every done pulse the DUT produces.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Present one request for a single cycle from an IDLE negedge; the
    // operands are scrambled right after acceptance.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        accepted++;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // cyc counts cycles from start assertion; 1 = the cycle right after the
    // accepting edge. Bounded by LIMIT.
    task automatic wait_done(output int cyc, output int busy_seen);
        cyc = 1;
        busy_seen = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            if (busy === 1'b1) busy_seen++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0)
            $display("FAIL reset_state: got %b, need 0", {busy, done, quotient, remainder, div_by_zero});
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   cyc, bs;
        exp_t e;
        start_op(8'd100, 8'd7);
        wait_done(cyc, bs);
        e = sb.pop_front();
        total++;
        if (cyc != W + 1) $display("FAIL basic_latency: got %0d, need %0d", cyc, W + 1);
        else passed++;
        total++;
        if (bs != W) $display("FAIL basic_busy_cycles: got %0d, need %0d", bs, W);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b, need 0", busy);
        else passed++;
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0} || e !== {8'd14, 8'd2, 1'b0})
            $display("FAIL basic_result: got q=%0d r=%0d z=%b, need q=14 r=2 z=0", quotient, remainder, div_by_zero);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, quotient, remainder, div_by_zero} !== {1'b0, e})
            $display("FAIL basic_hold: got done=%b q=%0d r=%0d, need done=0 q=%0d r=%0d", done, quotient, remainder, e.q, e.r);
        else passed++;
    endtask

    task automatic test_boundary();
        logic [W-1:0] as [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
        logic [W-1:0] bs_ [4] = '{8'd1, 8'd255, 8'd9, 8'd3};
        int   cyc, bs;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            start_op(as[i], bs_[i]);
            wait_done(cyc, bs);
            e = sb.pop_front();
            total++;
            if (cyc != W + 1) $display("FAIL boundary_latency[%0d]: got %0d, need %0d", i, cyc, W + 1);
            else passed++;
            total++;
            if ({quotient, remainder, div_by_zero} !== e)
                $display("FAIL boundary_result[%0d]: got q=%0d r=%0d z=%b, need q=%0d r=%0d z=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        int   cyc, bs;
        exp_t e;
        start_op(8'd200, 8'd0);
        wait_done(cyc, bs);
        e = sb.pop_front();
        total++;
        if (cyc != 1 || bs != 0 || busy !== 1'b0)
            $display("FAIL dbz_timing: got cyc=%0d busy_cycles=%0d busy=%b, need cyc=1 busy_cycles=0 busy=0", cyc, bs, busy);
        else passed++;
        total++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd200, 1'b1} || e !== {8'd255, 8'd200, 1'b1})
            $display("FAIL dbz_result: got q=%0d r=%0d z=%b, need q=255 r=200 z=1", quotient, remainder, div_by_zero);
        else passed++;
        start_op(8'd9, 8'd2);
        wait_done(cyc, bs);
        e = sb.pop_front();
        total++;
        if (cyc != W + 1 || {quotient, remainder, div_by_zero} !== {8'd4, 8'd1, 1'b0})
            $display("FAIL dbz_followup: got cyc=%0d q=%0d r=%0d z=%b, need cyc=%0d q=4 r=1 z=0",
                     cyc, quotient, remainder, div_by_zero, W + 1);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        int   cyc, bs, base;
        exp_t e;
        @(negedge clk);
        base = done_cnt;
        start_op(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(cyc, bs);
        e = sb.pop_front();
        total++;
        if (cyc != W - 2 || {quotient, remainder, div_by_zero} !== e)
            $display("FAIL busy_ignore: got cyc=%0d q=%0d r=%0d, need cyc=%0d q=%0d r=%0d",
                     cyc, quotient, remainder, W - 2, e.q, e.r);
        else passed++;
        start_op(8'd50, 8'd5);
        wait_done(cyc, bs);
        e = sb.pop_front();
        total++;
        if (cyc != W + 1 || {quotient, remainder, div_by_zero} !== {8'd10, 8'd0, 1'b0})
            $display("FAIL busy_b2b: got cyc=%0d q=%0d r=%0d, need cyc=%0d q=10 r=0", cyc, quotient, remainder, W + 1);
        else passed++;
        @(negedge clk);
        total++;
        if (done_cnt - base != 2) $display("FAIL busy_done_count: got %0d, need 2", done_cnt - base);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int   cyc, bs, base;
        exp_t e;
        base = done_cnt;
        start_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0)
            $display("FAIL reset_mid_outputs: got %b, need 0", {busy, done, quotient, remainder, div_by_zero});
        else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        e = sb.pop_back();
        accepted--;
        repeat (W + 2) @(negedge clk);
        total++;
        if (done_cnt != base) $display("FAIL reset_mid_no_done: got %0d, need %0d", done_cnt - base, 0);
        else passed++;
        start_op(8'd100, 8'd7);
        wait_done(cyc, bs);
        e = sb.pop_front();
        total++;
        if (cyc != W + 1 || {quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0})
            $display("FAIL reset_mid_recover: got cyc=%0d q=%0d r=%0d, need cyc=%0d q=14 r=2", cyc, quotient, remainder, W + 1);
        else passed++;
    endtask

    task automatic test_held_start();
        int   cyc, bs;
        exp_t e;
        dividend = 8'd20;
        divisor  = 8'd3;
        start    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(model(8'd20, 8'd3));
            accepted++;
            @(negedge clk);
            if (k == 2) start = 1'b0;
            wait_done(cyc, bs);
            e = sb.pop_front();
            total++;
            if (cyc != W + 1 || {quotient, remainder, div_by_zero} !== {8'd6, 8'd2, 1'b0})
                $display("FAIL held_start[%0d]: got cyc=%0d q=%0d r=%0d, need cyc=%0d q=6 r=2", k, cyc, quotient, remainder, W + 1);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int           cyc, bs;
        exp_t         e;
        logic [W-1:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom_range(0, 255));
            start_op(a, b);
            wait_done(cyc, bs);
            e = sb.pop_front();
            total++;
            if (cyc != ((b == 0) ? 1 : W + 1))
                $display("FAIL rand_latency[%0d]: %0d/%0d got %0d cycles", i, a, b, cyc);
            else passed++;
            total++;
            if ({quotient, remainder, div_by_zero} !== e)
                $display("FAIL rand_result[%0d]: %0d/%0d got q=%0d r=%0d z=%b, need q=%0d r=%0d z=%b",
                         i, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (done_cnt != accepted || sb.size() != 0)
            $display("FAIL done_count: got %0d dones (%0d pending), need %0d", done_cnt, sb.size(), accepted);
        else passed++;
    endtask

    initial begin
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset_n  = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid();
        test_held_start();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
